run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//  Run/halt/single-step sequencer for the three-phase clock generator (cycle, ram, internal).
//  Takes host commands and drives the generator's halt and reset inputs.
//  Halting always happens on a completed instruction cycle. Counts executed cycles and reports why it stopped.
// PARAMETERS
//  CNT_W   16  width of executed-cycle counter (wraps modulo 2^CNT_W)
//  STEP_W  8   width of step_count / internal steps-remaining counter
// PORTS
//  clk         in   1       system clock, all state on posedge
//  reset       in   1       asynchronous, active-high; forces reset values immediately
//  cmd_valid   in   1       host command strobe
//  cmd         in   2       00 NOP, 01 RUN, 10 STOP, 11 STEP
//  step_count  in   STEP_W  cycles to execute for STEP (sampled with cmd)
//  cmd_ready   out  1       command accepted on edge where cmd_valid & cmd_ready
//  cmd_err     out  1       1-cycle pulse: RUN/STEP accepted while already running (ignored)
//  phase_in    in   3       {internal_clk, ram_clk, cycle_clk} from clock generator
//  hlt_instr   in   1       CPU decoded a halt instruction (valid at cycle end)
//  bp_hit      in   1       breakpoint match (valid at cycle end)
//  gen_halt    out  1       to generator halt
//  gen_rst     out  1       to generator reset (re-sync phase to internal)
//  running     out  1       1 in RUN/STEP/DRAIN
//  done        out  1       1-cycle pulse on return to IDLE
//  stop_cause  out  2       00 HOST, 01 STEPS, 10 HLT, 11 BREAK; held until next start
//  cycles      out  CNT_W   completed cycles since reset
// BEHAVIOUR
//  All outputs are registered.
//  Reset values:
//   - state IDLE, gen_halt=1, gen_rst=0, running=0, done=0, cmd_err=0
//   - stop_cause=00, cycles=0, steps_left=0, cmd_ready=1
//  Cycle end (CE): rising edge with phase_in==3'b100 & gen_halt==0 & state in RUN/STEP/DRAIN.
//   - cycles increments on every CE.
//  States:
//   IDLE : gen_halt=1. cmd_ready=1. Command handling:
//          - RUN: go to SYNC.
//          - STEP, count>0: load steps_left; go to SYNC.
//          - STEP, count==0: stay IDLE; done pulse next cycle; stop_cause=01.
//          - STOP or NOP: no effect, no done.
//   SYNC : exactly 1 cycle. gen_halt=0, gen_rst=1, cmd_ready=0.
//          Next state is RUN or STEP, chosen by the latched command.
//   RUN  : gen_halt=0, gen_rst=0, cmd_ready=1.
//          - STOP accepted on a non-CE edge: go to DRAIN.
//          - STOP accepted on a CE edge: halt at that CE.
//          - RUN or STEP accepted: cmd_err pulse, otherwise ignored.
//   STEP : same as RUN. steps_left decrements on each CE.
//          Stops with cause 01 at the CE where steps_left goes 1->0.
//   DRAIN: cmd_ready=0. Stops at the next CE, cause 00.
//  Stop at a CE:
//   - Same edge: state to IDLE, gen_halt<=1, running<=0.
//   - Following cycle: done=1.
//   - That CE is counted in cycles.
//  Stop priority at the same CE: bp_hit(11) > hlt_instr(10) > steps exhausted(01) > host STOP(00).
//  bp_hit and hlt_instr are sampled only at CE. Both are ignored in IDLE and SYNC.
//  stop_cause is cleared to 00 on entry to SYNC.
//  Reset mid-operation:
//   - Immediate return to reset values, gen_halt=1.
//   - No done pulse. The pending step count is discarded.
// TESTING
//  T1: reset; STEP count=3 -> SYNC 1 cycle with gen_rst=1; 3 CEs; then gen_halt=1, cycles=3, stop_cause=01, one done pulse.
//  T2: RUN; STOP mid-cycle after 5 CEs -> DRAIN; halt at 6th CE; cycles=6, stop_cause=00.
//  T3: RUN; bp_hit=1 and hlt_instr=1 at CE #4 -> halt there, stop_cause=11, cycles=4.
//  T4: STEP count=0 in IDLE -> no SYNC, gen_halt stays 1, done pulse, cycles unchanged, stop_cause=01.
//  T5: RUN; issue RUN again -> cmd_err 1-cycle pulse, state stays RUN; STOP exactly on a CE -> halt that CE, no DRAIN.
//  T6: CNT_W=4, RUN 17 CEs then STOP on CE -> cycles=1 (wrap). Separately, async reset mid-STEP -> gen_halt=1 without clock, no done.

Source files
------------

// File: rtl/run_ctrl.sv
// Run/halt/single-step sequencer for the three-phase clock generator.
// Halts only on completed instruction cycles, counts cycles and records the stop cause.
module run_ctrl #(
  parameter int CNT_W  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] step_count,
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic [2:0]        phase_in,
  input  logic              hlt_instr,
  input  logic              bp_hit,
  output logic              gen_halt,
  output logic              gen_rst,
  output logic              running,
  output logic              done,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b10;
  localparam logic [1:0] CMD_STEP = 2'b11;

  localparam logic [1:0] CAUSE_HOST  = 2'b00;
  localparam logic [1:0] CAUSE_STEPS = 2'b01;
  localparam logic [1:0] CAUSE_HLT   = 2'b10;
  localparam logic [1:0] CAUSE_BREAK = 2'b11;

  state_t            state, state_n;
  logic              step_mode, step_mode_n;
  logic [STEP_W-1:0] steps_left, steps_left_n;
  logic [1:0]        stop_cause_n;
  logic              done_n, cmd_err_n;
  logic              gen_halt_n, gen_rst_n, running_n, cmd_ready_n;
  logic              accept, active, ce, steps_out, host_stop;
  logic [1:0]        ce_cause;

  assign accept    = cmd_valid & cmd_ready;
  assign active    = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
  assign ce        = active && (phase_in == 3'b100) && !gen_halt;
  assign steps_out = (steps_left == STEP_W'(1));
  assign host_stop = accept && (cmd == CMD_STOP);

  // Highest-priority reason for halting if this edge turns out to be a stopping CE
  always_comb begin
    if (bp_hit)         ce_cause = CAUSE_BREAK;
    else if (hlt_instr) ce_cause = CAUSE_HLT;
    else if (steps_out) ce_cause = CAUSE_STEPS;
    else                ce_cause = CAUSE_HOST;
  end

  always_comb begin
    state_n      = state;
    step_mode_n  = step_mode;
    steps_left_n = steps_left;
    stop_cause_n = stop_cause;
    done_n       = 1'b0;
    cmd_err_n    = 1'b0;
    if (ce && (steps_left != '0))
      steps_left_n = steps_left - STEP_W'(1);
    case (state)
      S_IDLE: begin
        if (accept && (cmd == CMD_RUN)) begin
          state_n      = S_SYNC;
          step_mode_n  = 1'b0;
          steps_left_n = '0;
          stop_cause_n = CAUSE_HOST;
        end else if (accept && (cmd == CMD_STEP)) begin
          if (step_count != '0) begin
            state_n      = S_SYNC;
            step_mode_n  = 1'b1;
            steps_left_n = step_count;
            stop_cause_n = CAUSE_HOST;
          end else begin
            done_n       = 1'b1;
            stop_cause_n = CAUSE_STEPS;
          end
        end
      end
      S_SYNC: state_n = step_mode ? S_STEP : S_RUN;
      S_RUN, S_STEP: begin
        if (accept && ((cmd == CMD_RUN) || (cmd == CMD_STEP)))
          cmd_err_n = 1'b1;
        if (ce && (bp_hit || hlt_instr || steps_out || host_stop)) begin
          state_n      = S_IDLE;
          done_n       = 1'b1;
          stop_cause_n = ce_cause;
        end else if (host_stop) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ce) begin
          state_n      = S_IDLE;
          done_n       = 1'b1;
          stop_cause_n = ce_cause;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered so they line up with it
  always_comb begin
    gen_halt_n  = (state_n == S_IDLE);
    gen_rst_n   = (state_n == S_SYNC);
    running_n   = (state_n == S_RUN) || (state_n == S_STEP) || (state_n == S_DRAIN);
    cmd_ready_n = (state_n == S_IDLE) || (state_n == S_RUN) || (state_n == S_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      step_mode  <= 1'b0;
      steps_left <= '0;
      stop_cause <= CAUSE_HOST;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
      gen_halt   <= 1'b1;
      gen_rst    <= 1'b0;
      running    <= 1'b0;
      cmd_ready  <= 1'b1;
      cycles     <= '0;
    end else begin
      state      <= state_n;
      step_mode  <= step_mode_n;
      steps_left <= steps_left_n;
      stop_cause <= stop_cause_n;
      done       <= done_n;
      cmd_err    <= cmd_err_n;
      gen_halt   <= gen_halt_n;
      gen_rst    <= gen_rst_n;
      running    <= running_n;
      cmd_ready  <= cmd_ready_n;
      if (ce)
        cycles <= cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: a 16-bit and a 4-bit counter instance share one stimulus,
// with a simple three-phase generator model closing the loop on gen_halt/gen_rst.
module tb_run_ctrl;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STOP = 2'b10;
  localparam logic [1:0] CMD_STEP = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [7:0]  step_count;
  logic [2:0]  phase_in;
  logic        hlt_instr;
  logic        bp_hit;

  logic        cmd_ready, cmd_err, gen_halt, gen_rst, running, done;
  logic [1:0]  stop_cause;
  logic [15:0] cycles;

  logic        cmd_ready_w, cmd_err_w, gen_halt_w, gen_rst_w, running_w, done_w;
  logic [1:0]  stop_cause_w;
  logic [3:0]  cycles_w;

  typedef struct {
    logic [1:0]  cause;
    logic [15:0] cyc;
    logic [3:0]  cyc4;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  run_ctrl #(.CNT_W(16), .STEP_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .step_count(step_count),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .phase_in(phase_in), .hlt_instr(hlt_instr),
    .bp_hit(bp_hit), .gen_halt(gen_halt), .gen_rst(gen_rst), .running(running), .done(done),
    .stop_cause(stop_cause), .cycles(cycles)
  );

  run_ctrl #(.CNT_W(4), .STEP_W(8)) dut_w (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .step_count(step_count),
    .cmd_ready(cmd_ready_w), .cmd_err(cmd_err_w), .phase_in(phase_in), .hlt_instr(hlt_instr),
    .bp_hit(bp_hit), .gen_halt(gen_halt_w), .gen_rst(gen_rst_w), .running(running_w), .done(done_w),
    .stop_cause(stop_cause_w), .cycles(cycles_w)
  );

  always #5 clk = ~clk;

  // Clock generator model: parked on the cycle phase while halted or resyncing, else rotates
  always @(posedge clk or posedge reset) begin
    if (reset)                  phase_in <= 3'b001;
    else if (gen_halt || gen_rst) phase_in <= 3'b001;
    else                        phase_in <= {phase_in[1:0], phase_in[2]};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected halt
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_cause"},    32'(stop_cause), 32'(e.cause));
        checkOutput({e.name, "_cycles"},   32'(cycles),     32'(e.cyc));
        checkOutput({e.name, "_cycles4"},  32'(cycles_w),   32'(e.cyc4));
        checkOutput({e.name, "_done4"},    32'(done_w),     32'd1);
        checkOutput({e.name, "_halt"},     32'(gen_halt),   32'd1);
        checkOutput({e.name, "_running"},  32'(running),    32'd0);
      end
    end else if (!reset && done_w) begin
      checkOutput("unexpected_done4", 32'(done_w), 32'd0);
    end
  end

  task automatic expectHalt(input logic [1:0] cause, input logic [15:0] cyc, input logic [3:0] cyc4, input string name);
    exp_t e;
    e.cause = cause;
    e.cyc   = cyc;
    e.cyc4  = cyc4;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; holds the command for exactly one rising edge
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] n);
    cmd_valid  = 1'b1;
    cmd        = c;
    step_count = n;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    step_count = 8'd0;
  endtask

  task automatic waitNextCe(input string name);
    int i = 0;
    while (phase_in != 3'b100 && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (phase_in != 3'b100)
      checkOutput({name, "_ce_timeout"}, 32'(phase_in), 32'd4);
  endtask

  task automatic passCes(input int n, input string name);
    repeat (n) begin
      waitNextCe(name);
      @(negedge clk);
    end
  endtask

  task automatic waitDone(input string name);
    int i = 0;
    while (!done && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!done)
      checkOutput({name, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    step_count = 8'd0;
    hlt_instr  = 1'b0;
    bp_hit     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_gen_halt",   32'(gen_halt),   32'd1);
    checkOutput("rst_gen_rst",    32'(gen_rst),    32'd0);
    checkOutput("rst_running",    32'(running),    32'd0);
    checkOutput("rst_done",       32'(done),       32'd0);
    checkOutput("rst_cmd_err",    32'(cmd_err),    32'd0);
    checkOutput("rst_stop_cause", 32'(stop_cause), 32'd0);
    checkOutput("rst_cycles",     32'(cycles),     32'd0);
    checkOutput("rst_cmd_ready",  32'(cmd_ready),  32'd1);

    // T1: STEP 3 goes through one SYNC cycle then halts on the third CE
    expectHalt(2'b01, 16'd3, 4'd3, "t1");
    applyStimulus(CMD_STEP, 8'd3);
    checkOutput("t1_sync_gen_rst",   32'(gen_rst),   32'd1);
    checkOutput("t1_sync_gen_halt",  32'(gen_halt),  32'd0);
    checkOutput("t1_sync_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("t1_sync_running",   32'(running),   32'd0);
    @(negedge clk);
    checkOutput("t1_step_gen_rst",   32'(gen_rst),   32'd0);
    checkOutput("t1_step_running",   32'(running),   32'd1);
    waitDone("t1");
    @(negedge clk);
    checkOutput("t1_done_single",    32'(done),      32'd0);
    checkOutput("t1_halt_held",      32'(gen_halt),  32'd1);

    // T2: STOP between CEs drains to the next CE
    doReset();
    expectHalt(2'b00, 16'd6, 4'd6, "t2");
    applyStimulus(CMD_RUN, 8'd0);
    passCes(5, "t2");
    applyStimulus(CMD_STOP, 8'd0);
    checkOutput("t2_drain_running",   32'(running),   32'd1);
    checkOutput("t2_drain_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("t2_drain_cycles",    32'(cycles),    32'd5);
    waitDone("t2");
    @(negedge clk);

    // T3: breakpoint outside a CE is ignored; bp+hlt together at CE 4 report BREAK
    doReset();
    expectHalt(2'b11, 16'd4, 4'd4, "t3");
    applyStimulus(CMD_RUN, 8'd0);
    passCes(2, "t3");
    bp_hit    = 1'b1;
    hlt_instr = 1'b1;
    @(negedge clk);
    bp_hit    = 1'b0;
    hlt_instr = 1'b0;
    checkOutput("t3_nonce_bp_ignored", 32'(running), 32'd1);
    passCes(1, "t3");
    waitNextCe("t3");
    bp_hit    = 1'b1;
    hlt_instr = 1'b1;
    @(negedge clk);
    bp_hit    = 1'b0;
    hlt_instr = 1'b0;
    waitDone("t3");
    @(negedge clk);

    // T4: STEP 0 in IDLE completes immediately without starting the generator
    expectHalt(2'b01, 16'd4, 4'd4, "t4");
    applyStimulus(CMD_STEP, 8'd0);
    checkOutput("t4_gen_halt", 32'(gen_halt), 32'd1);
    checkOutput("t4_gen_rst",  32'(gen_rst),  32'd0);
    checkOutput("t4_done",     32'(done),     32'd1);
    @(negedge clk);
    checkOutput("t4_done_single", 32'(done), 32'd0);

    // T5: RUN while running flags cmd_err; STOP on a CE halts without draining
    doReset();
    expectHalt(2'b00, 16'd3, 4'd3, "t5");
    applyStimulus(CMD_RUN, 8'd0);
    passCes(2, "t5");
    applyStimulus(CMD_RUN, 8'd0);
    checkOutput("t5_cmd_err_pulse", 32'(cmd_err), 32'd1);
    checkOutput("t5_still_running", 32'(running), 32'd1);
    @(negedge clk);
    checkOutput("t5_cmd_err_clear", 32'(cmd_err), 32'd0);
    waitNextCe("t5");
    applyStimulus(CMD_STOP, 8'd0);
    checkOutput("t5_no_drain_running", 32'(running),   32'd0);
    checkOutput("t5_no_drain_ready",   32'(cmd_ready), 32'd1);
    @(negedge clk);

    // T6: 17 CEs wrap the 4-bit counter to 1
    doReset();
    expectHalt(2'b00, 16'd17, 4'd1, "t6");
    applyStimulus(CMD_RUN, 8'd0);
    passCes(16, "t6");
    waitNextCe("t6");
    applyStimulus(CMD_STOP, 8'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a long STEP: no clock edge, no done
    doReset();
    applyStimulus(CMD_STEP, 8'd200);
    passCes(2, "ar");
    checkOutput("ar_pre_gen_halt", 32'(gen_halt), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_gen_halt",   32'(gen_halt),   32'd1);
    checkOutput("ar_gen_halt4",  32'(gen_halt_w), 32'd1);
    checkOutput("ar_running",    32'(running),    32'd0);
    checkOutput("ar_cmd_ready",  32'(cmd_ready),  32'd1);
    checkOutput("ar_done",       32'(done),       32'd0);
    checkOutput("ar_cycles",     32'(cycles),     32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("ar_idle_halt",  32'(gen_halt),   32'd1);
    checkOutput("ar_stop_cause", 32'(stop_cause), 32'd0);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
